// File: rtl/bf16_mul_round_pack_pkg.sv
// bf16_mul_round_pack_pkg
//   Shared definitions for the bfloat16 round/pack stage: operand class
//   codes, default exponent bias and canonical NaN, status flag bit
//   positions, the stage-1 pipeline payload and small packing helpers.
package bf16_mul_round_pack_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  localparam int          BIAS_DEF = 127;
  localparam logic [15:0] QNAN_DEF = 16'h7FC0;

  // Bit positions inside out_flags = {OF, UF, NX}
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Normalized product held between stage 1 and stage 2
  typedef struct packed {
    logic               s;
    cls_e               cls;
    logic [6:0]         mant;
    logic               g;
    logic               st;
    logic signed [9:0]  e;
  } s1_t;

  function automatic logic [15:0] inf_word(input logic s);
    return {s, 8'hFF, 7'h00};
  endfunction

  function automatic logic [15:0] zero_word(input logic s);
    return {s, 15'h0000};
  endfunction

endpackage

// File: rtl/bf16_mul_round_pack_if.sv
// bf16_mul_round_pack_if
//   Valid/ready bundle around the round/pack stage.
//   Upstream side : in_valid, in_ready, in_prod, in_exp_a, in_exp_b, in_s, in_cls
//   Downstream side: out_valid, out_ready, out_data, out_flags
//   slave  : the round/pack stage itself
//   master : whoever feeds products and consumes results
interface bf16_mul_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic [7:0]  in_exp_a;
  logic [7:0]  in_exp_b;
  logic        in_s;
  logic [1:0]  in_cls;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_flags;

  modport slave (
    input  in_valid, in_prod, in_exp_a, in_exp_b, in_s, in_cls, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_prod, in_exp_a, in_exp_b, in_s, in_cls, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/bf16_rne_round.sv
// bf16_rne_round
//   Combinational round-to-nearest-even and pack for a normalized product.
//   i_s    : result sign
//   i_mant : 7-bit fraction before rounding
//   i_g    : guard bit, i_st : sticky bit
//   i_e    : rebiased exponent before rounding (signed)
//   o_word : packed bfloat16 (overflow saturates to infinity)
//   o_of   : exponent overflow after rounding
//   o_nx   : result is inexact
module bf16_rne_round
  import bf16_mul_round_pack_pkg::*;
(
  input  logic              i_s,
  input  logic [6:0]        i_mant,
  input  logic              i_g,
  input  logic              i_st,
  input  logic signed [9:0] i_e,
  output logic [15:0]       o_word,
  output logic              o_of,
  output logic              o_nx
);

  logic              w_up;
  logic [7:0]        w_sum;
  logic signed [9:0] w_e_final;

  assign w_up  = i_g & (i_st | i_mant[0]);
  assign w_sum = {1'b0, i_mant} + {7'd0, w_up};

  // A carry out of the fraction means the significand reached 2.0: the low
  // seven bits are already zero, so only the exponent has to step.
  assign w_e_final = i_e + $signed({9'd0, w_sum[7]});

  assign o_of   = (w_e_final >= 10'sd255);
  assign o_nx   = o_of | i_g | i_st;
  assign o_word = o_of ? inf_word(i_s) : {i_s, w_e_final[7:0], w_sum[6:0]};

endmodule

// File: rtl/bf16_mul_round_pack.sv
// bf16_mul_round_pack
//   Two-stage pipeline after the bfloat16 significand multiplier.
//   Stage 1 normalizes the 1.7x1.7 product and rebiases the exponent;
//   stage 2 rounds to nearest-even, applies underflow flush and class
//   overrides, and registers the packed word with {OF, UF, NX}.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : valid/ready bundle (slave side), see bf16_mul_round_pack_if
module bf16_mul_round_pack
  import bf16_mul_round_pack_pkg::*;
#(
  parameter int          BIAS = BIAS_DEF,
  parameter logic [15:0] QNAN = QNAN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  bf16_mul_round_pack_if.slave   bus
);

  logic        w_s2_adv;
  logic        w_in_ready;
  logic        w_n;
  s1_t         w_s1_next;
  logic        r_s1_valid;
  s1_t         r_s1;

  logic [15:0] w_rnd_word;
  logic        w_rnd_of;
  logic        w_rnd_nx;
  logic [15:0] w_res_data;
  logic [2:0]  w_res_flags;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic [2:0]  r_out_flags;

  // Stage 2 frees up when empty or drained this cycle; stage 1 when empty
  // or moving into stage 2. Two results fit before upstream is stalled.
  assign w_s2_adv   = ~r_out_valid | bus.out_ready;
  assign w_in_ready = ~r_s1_valid | w_s2_adv;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_flags = r_out_flags;

  // ---------------- stage 1: normalize ----------------
  // NOTE: every field is assigned on every path so no latch is inferred.
  always_comb begin
    w_n           = bus.in_prod[15];
    w_s1_next.s   = bus.in_s;
    w_s1_next.cls = cls_e'(bus.in_cls);
    if (w_n) begin
      w_s1_next.mant = bus.in_prod[14:8];
      w_s1_next.g    = bus.in_prod[7];
      w_s1_next.st   = |bus.in_prod[6:0];
    end else begin
      w_s1_next.mant = bus.in_prod[13:7];
      w_s1_next.g    = bus.in_prod[6];
      w_s1_next.st   = |bus.in_prod[5:0];
    end
    w_s1_next.e = $signed({2'b00, bus.in_exp_a}) + $signed({2'b00, bus.in_exp_b})
                - 10'(BIAS) + $signed({9'd0, w_n});
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
    end
  end

  // NOTE: the payload is deliberately not reset; r_s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_in_ready && bus.in_valid) begin
      r_s1 <= w_s1_next;
    end
  end

  // ---------------- stage 2: round / pack ----------------
  bf16_rne_round u_round (
    .i_s    (r_s1.s),
    .i_mant (r_s1.mant),
    .i_g    (r_s1.g),
    .i_st   (r_s1.st),
    .i_e    (r_s1.e),
    .o_word (w_rnd_word),
    .o_of   (w_rnd_of),
    .o_nx   (w_rnd_nx)
  );

  always_comb begin
    w_res_data  = w_rnd_word;
    w_res_flags = 3'b000;
    unique case (r_s1.cls)
      CLS_ZERO: w_res_data = zero_word(r_s1.s);
      CLS_INF:  w_res_data = inf_word(r_s1.s);
      CLS_NAN:  w_res_data = QNAN;
      default: begin
        // Underflow is judged on the pre-round exponent; no subnormals.
        if ($signed(r_s1.e) <= 10'sd0) begin
          w_res_data           = zero_word(r_s1.s);
          w_res_flags[FLAG_UF] = 1'b1;
          w_res_flags[FLAG_NX] = 1'b1;
        end else begin
          w_res_flags[FLAG_OF] = w_rnd_of;
          w_res_flags[FLAG_NX] = w_rnd_nx;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_flags <= 3'b000;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_res_data;
        r_out_flags <= w_res_flags;
      end
    end
  end

endmodule

// File: tb/tb_bf16_mul_round_pack.sv
// tb_bf16_mul_round_pack
//   Directed and randomized stimulus for bf16_mul_round_pack. Expected
//   results come from directed constants or from an integer model of the
//   normalize/round-to-nearest-even rules, queued in issue order.
module tb_bf16_mul_round_pack;
  import bf16_mul_round_pack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf16_mul_round_pack_if bus ();

  bf16_mul_round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  flags;
  } want_t;

  want_t want_q[$];
  want_t cur_want;
  int    n_vec  = 0;
  int    n_fail = 0;
  int    n_in   = 0;
  int    n_out  = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Exact-value model: significand = prod / 2^14 in [1,4).
  function automatic want_t ref_model(input logic [15:0] prod, input logic [7:0] ea,
                                      input logic [7:0] eb, input logic s,
                                      input logic [1:0] cls);
    want_t r;
    int sh, q, rem, half, e;
    r.flags = 3'b000;
    r.data  = 16'h0000;
    case (cls)
      2'b11: r.data = 16'h7FC0;
      2'b10: r.data = {s, 8'hFF, 7'h00};
      2'b01: r.data = {s, 15'h0000};
      default: begin
        sh   = (int'(prod) >= 32768) ? 8 : 7;
        q    = int'(prod) >> sh;
        rem  = int'(prod) % (1 << sh);
        half = 1 << (sh - 1);
        e    = int'(ea) + int'(eb) - 127 + (sh - 7);
        if (e <= 0) begin
          r.data  = {s, 15'h0000};
          r.flags = 3'b011;
        end else begin
          if (rem > half || (rem == half && (q % 2) == 1)) q++;
          if (q == 256) begin
            q = 128;
            e++;
          end
          if (e >= 255) begin
            r.data  = {s, 8'hFF, 7'h00};
            r.flags = 3'b101;
          end else begin
            r.data  = {s, 8'(e), 7'(q)};
            r.flags = {2'b00, rem != 0};
          end
        end
      end
    endcase
    return r;
  endfunction

  // One clock: observe handshakes just before the edge, then step past it.
  task automatic tick(output bit acc);
    want_t h;
    #2;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      check("out_has_pending", 32'(want_q.size() != 0), 1);
      if (want_q.size() != 0) begin
        h = want_q.pop_front();
        check("out_data", bus.out_data, h.data);
        check("out_flags", bus.out_flags, h.flags);
        n_out++;
      end
    end
    acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    if (acc) begin
      want_q.push_back(cur_want);
      n_in++;
    end
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input logic [15:0] prod, input logic [7:0] ea, input logic [7:0] eb,
                       input logic s, input logic [1:0] cls, input want_t w);
    bus.in_prod  = prod;
    bus.in_exp_a = ea;
    bus.in_exp_b = eb;
    bus.in_s     = s;
    bus.in_cls   = cls;
    bus.in_valid = 1'b1;
    cur_want     = w;
  endtask

  task automatic wait_accept();
    bit acc;
    int waited = 0;
    do begin
      tick(acc);
      waited++;
    end while (!acc && waited < 64);
    check("in_accepted", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] prod, input logic [7:0] ea, input logic [7:0] eb,
                      input logic s, input logic [1:0] cls, input logic [15:0] data,
                      input logic [2:0] flags);
    want_t w;
    w.data  = data;
    w.flags = flags;
    drive(prod, ea, eb, s, cls, w);
    wait_accept();
  endtask

  task automatic send_rand();
    logic [15:0] prod;
    logic [7:0]  ea, eb;
    logic        s;
    logic [1:0]  cls;
    prod = 16'($urandom_range(16'h4000, 16'hFFFF));
    if ($urandom_range(0, 1) == 0) begin
      ea = 8'($urandom_range(0, 255));
      eb = 8'($urandom_range(0, 255));
    end else begin
      ea = 8'($urandom_range(100, 160));
      eb = 8'($urandom_range(100, 160));
    end
    s   = 1'($urandom_range(0, 1));
    cls = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    drive(prod, ea, eb, s, cls, ref_model(prod, ea, eb, s, cls));
    wait_accept();
  endtask

  task automatic drain();
    bit acc;
    int waited = 0;
    bus.in_valid = 1'b0;
    while (want_q.size() != 0 && waited < 200) begin
      tick(acc);
      waited++;
    end
    check("drain_empty", want_q.size(), 0);
  endtask

  initial begin
    bit acc;
    want_t w;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_prod   = 16'h0000;
    bus.in_exp_a  = 8'h00;
    bus.in_exp_b  = 8'h00;
    bus.in_s      = 1'b0;
    bus.in_cls    = 2'b00;
    bus.out_ready = 1'b1;
    tick(acc);
    tick(acc);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 16'h0000);
    check("rst_out_flags", bus.out_flags, 3'b000);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed values
    send(16'h4000, 8'd127, 8'd127, 1'b0, CLS_NORM, 16'h3F80, 3'b000);
    send(16'h9000, 8'd127, 8'd127, 1'b0, CLS_NORM, 16'h4010, 3'b000);
    send(16'h60C0, 8'd127, 8'd127, 1'b0, CLS_NORM, 16'h3FC2, 3'b001);
    send(16'h6240, 8'd127, 8'd127, 1'b0, CLS_NORM, 16'h3FC4, 3'b001);
    send(16'h4000, 8'd254, 8'd254, 1'b0, CLS_NORM, 16'h7F80, 3'b101);
    send(16'h4000, 8'd1,   8'd1,   1'b1, CLS_NORM, 16'h8000, 3'b011);
    send(16'h4000, 8'd127, 8'd127, 1'b0, CLS_NAN,  16'h7FC0, 3'b000);
    send(16'h4000, 8'd127, 8'd127, 1'b1, CLS_INF,  16'hFF80, 3'b000);
    send(16'h4000, 8'd127, 8'd127, 1'b0, CLS_ZERO, 16'h0000, 3'b000);
    // Rounding carry into the exponent: 1.11111111 -> 2.0
    send(16'h7FE0, 8'd127, 8'd127, 1'b0, CLS_NORM, 16'h4000, 3'b001);
    drain();

    // Backpressure: two results buffered, then upstream stalls
    bus.out_ready = 1'b0;
    drive(16'h4000, 8'd127, 8'd128, 1'b0, CLS_NORM, ref_model(16'h4000, 8'd127, 8'd128, 1'b0, 2'b00));
    tick(acc);
    check("bp_accept_a", acc, 1);
    drive(16'h9000, 8'd130, 8'd120, 1'b1, CLS_NORM, ref_model(16'h9000, 8'd130, 8'd120, 1'b1, 2'b00));
    tick(acc);
    check("bp_accept_b", acc, 1);
    drive(16'h60C0, 8'd140, 8'd100, 1'b0, CLS_NORM, ref_model(16'h60C0, 8'd140, 8'd100, 1'b0, 2'b00));
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_data, want_q[0].data);
      check("bp_hold_flags", bus.out_flags, want_q[0].flags);
      tick(acc);
    end
    bus.out_ready = 1'b1;
    wait_accept();
    w = ref_model(16'hC3A1, 8'd125, 8'd126, 1'b1, 2'b00);
    send(16'hC3A1, 8'd125, 8'd126, 1'b1, CLS_NORM, w.data, w.flags);
    drain();
    check("bp_in_out_count", n_out, n_in);

    // Randomized traffic with random backpressure and idle gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.in_valid = 1'b0;
        tick(acc);
      end else begin
        send_rand();
      end
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check("rand_in_out_count", n_out, n_in);

    // Reset mid-stream discards both stages
    bus.out_ready = 1'b0;
    drive(16'h5555, 8'd127, 8'd127, 1'b0, CLS_NORM, ref_model(16'h5555, 8'd127, 8'd127, 1'b0, 2'b00));
    tick(acc);
    tick(acc);
    bus.in_valid = 1'b0;
    check("mid_out_valid_before_rst", bus.out_valid, 1);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    want_q.delete();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(acc);
    send(16'h4000, 8'd127, 8'd127, 1'b0, CLS_NORM, 16'h3F80, 3'b000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
